modulation_sync_idx_gen: RTL and testbench
==========================================

# modulation_sync_idx_gen

Generates the per-segment modulation sample index `SYNC_IDX` and its wrap strobe, which the modulation swapchain consumes for segment switching and loop counting. Each segment has a free-running divider that advances a sample index every `FREQ_DIV` clocks and wraps it after `CYCLE`. New cycle and divider settings are double-buffered and take effect at the segment's next wrap, so consumers only see index 0 at a settings boundary. A `SYNC` pulse from the EtherCAT sync logic realigns all segments.

## Interface
- `NumSegment`, default `params::NumSegment` (2): number of independent segments.
- `CLK` input 1: system clock; all logic is on its rising edge.
- `RST_N` input 1: reset, asynchronous and active-low.
- `SYNC` input 1: one-cycle pulse that realigns all segment counters to zero.
- `UPDATE_SETTINGS` input 1: one-cycle pulse; captures `CYCLE`/`FREQ_DIV` of segment `UPDATE_SEGMENT` into its shadow register.
- `UPDATE_SEGMENT` input $clog2(NumSegment): segment targeted by `UPDATE_SETTINGS`.
- `CYCLE` input 16: last index, inclusive (index runs 0..`CYCLE`).
- `FREQ_DIV` input 16: clocks per index step; 0 is treated as 1.
- `SYNC_IDX[NumSegment]` output 16 each: current sample index per segment, registered.
- `WRAP[NumSegment]` output 1 each: one-cycle pulse in the same cycle `SYNC_IDX` returns to 0 by wrap.
- `PENDING[NumSegment]` output 1 each: high while a shadow setting is waiting for the next wrap.

## Operation
- Per-segment state:
  - active registers `cyc_a` and `div_a`;
  - shadow registers `cyc_s` and `div_s`;
  - `pend` flag;
  - 16-bit `div_cnt`;
  - 16-bit `idx`.
- Effective divider: `eff_div = (div_a == 0) ? 1 : div_a`.
- Every clock, with no `SYNC`:
  - If `div_cnt == eff_div-1`: `div_cnt<=0`, and one of:
    - if `idx == cyc_a`: `idx<=0` and `WRAP<=1`. If `pend`, also load `cyc_a<=cyc_s`, `div_a<=div_s`, `pend<=0`.
    - else `idx<=idx+1`.
  - Otherwise `div_cnt<=div_cnt+1`, `WRAP<=0`.
- `UPDATE_SETTINGS`:
  - `cyc_s<=CYCLE`, `div_s<=FREQ_DIV`, `pend<=1` for `UPDATE_SEGMENT` only.
  - A second update before the wrap overwrites the shadow; the last one wins.
- `SYNC`, all segments:
  - `div_cnt<=0`, `idx<=0`, `WRAP<=0`.
  - Any pending shadow is applied immediately and `pend<=0`.
- `SYNC` and `UPDATE_SETTINGS` in the same cycle: the new values go straight into the active registers of the target segment, and `pend` ends 0.
- `UPDATE_SETTINGS` in the same cycle as a wrap of the target segment:
  - the wrap loads the old shadow, if one is pending;
  - the new value becomes the shadow with `pend=1`.
- Arithmetic:
  - `idx` compare is equality only; no saturation is needed because wrap occurs at `cyc_a`.
  - Counters are 16-bit unsigned; `div_cnt` never exceeds 65534.
- `CYCLE=0`: `idx` stays 0, and `WRAP` pulses every `eff_div` clocks. This is a legal configuration; consumers relying on an index change see none.
- `UPDATE_SEGMENT` outside the valid range is ignored.

## Timing
- Reset values:
  - `SYNC_IDX=0`, `WRAP=0`, `PENDING=0`.
  - `cyc_a=0`, `div_a=0`, `div_cnt=0`.
  - Shadows are 0.
- Index step latency: `SYNC_IDX` changes on the clock edge where `div_cnt == eff_div-1`. Period is exactly `eff_div` clocks per step and `eff_div*(cyc_a+1)` clocks per full cycle.
- `SYNC` takes effect on the next edge, so the cycle after the pulse shows `SYNC_IDX=0`. Counting resumes from `div_cnt=0` the following cycle.
- `PENDING` rises on the edge after `UPDATE_SETTINGS` and falls on the wrap edge or `SYNC` edge that applies the shadow.
- Reset assertion mid-operation clears everything asynchronously. The first step after release occurs `eff_div` clocks after the first active edge.

## Test plan
- **Reset plus default:** release reset with no update. Expect `SYNC_IDX=0` forever and `WRAP` high every cycle (`CYCLE=0`, divider 1).
- **Basic counting:** `UPDATE_SETTINGS` with seg0, `CYCLE=3`, `FREQ_DIV=2`, then `SYNC`.
  - Seg0 index sequence 0,0,1,1,2,2,3,3,0…
  - `WRAP` is a one-cycle pulse every 8 clocks.
  - Seg1 is unaffected.
- **Deferred update:** running with `CYCLE=3`, `FREQ_DIV=2`; at `idx=1`, issue update `CYCLE=1`, `FREQ_DIV=1`.
  - `PENDING` stays 1 until the wrap.
  - The old sequence completes through 3; then 0,1,0,1 at 1 clock per step.
- **Overwrite plus same-cycle wrap:** issue two updates before the wrap (`CYCLE=5`, then `CYCLE=2`). Expect the active `CYCLE=2` after the wrap. An update coincident with the wrap edge leaves `PENDING=1` holding the new value.
- **SYNC mid-cycle:** at seg0 `idx=2` with a pending update, pulse `SYNC`. Expect `SYNC_IDX=0` on the next edge, no `WRAP` pulse, the shadow applied, and `PENDING=0`.
- **FREQ_DIV=0 plus async reset:** `FREQ_DIV=0` steps every clock. Asserting `RST_N` low mid-count zeroes the outputs without a clock edge.

Source files
------------

// File: rtl/modulation_sync_idx_gen.sv
// Per-segment modulation sample index generator with double-buffered cycle/divider
// settings applied at wrap, plus a global SYNC realignment.
package params;
  localparam int NumSegment = 2;
endpackage

module modulation_sync_idx_gen #(
  parameter int  NumSegment = params::NumSegment,
  localparam int SegW       = (NumSegment > 1) ? $clog2(NumSegment) : 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            SYNC,
  input  logic            UPDATE_SETTINGS,
  input  logic [SegW-1:0] UPDATE_SEGMENT,
  input  logic [15:0]     CYCLE,
  input  logic [15:0]     FREQ_DIV,
  output logic [15:0]     SYNC_IDX [NumSegment],
  output logic            WRAP     [NumSegment],
  output logic            PENDING  [NumSegment]
);

  for (genvar s = 0; s < NumSegment; s++) begin : g_seg
    logic [15:0] cyc_a, div_a, cyc_s, div_s;
    logic [15:0] div_cnt, idx;
    logic        pend, wrap;
    logic [15:0] eff_div;
    logic        hit, last_cnt, at_end;

    always_comb begin
      // Out-of-range segment numbers simply never match.
      hit      = UPDATE_SETTINGS && (int'(UPDATE_SEGMENT) == s);
      eff_div  = (div_a == 16'd0) ? 16'd1 : div_a;
      last_cnt = (div_cnt == eff_div - 16'd1);
      at_end   = (idx == cyc_a);
    end

    // NOTE: the segment holds only a handful of flops, so every register including
    // the shadows is reset; nothing here is a memory that could be left unreset.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cyc_a   <= '0;
        div_a   <= '0;
        cyc_s   <= '0;
        div_s   <= '0;
        div_cnt <= '0;
        idx     <= '0;
        pend    <= 1'b0;
        wrap    <= 1'b0;
      end else if (SYNC) begin
        div_cnt <= '0;
        idx     <= '0;
        wrap    <= 1'b0;
        pend    <= 1'b0;
        if (hit) begin
          cyc_a <= CYCLE;
          div_a <= FREQ_DIV;
          cyc_s <= CYCLE;
          div_s <= FREQ_DIV;
        end else if (pend) begin
          cyc_a <= cyc_s;
          div_a <= div_s;
        end
      end else begin
        wrap <= 1'b0;
        if (last_cnt) begin
          div_cnt <= '0;
          if (at_end) begin
            idx  <= '0;
            wrap <= 1'b1;
            if (pend) begin
              cyc_a <= cyc_s;
              div_a <= div_s;
              pend  <= 1'b0;
            end
          end else begin
            idx <= idx + 16'd1;
          end
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
        // NOTE: non-blocking updates resolve last-write-wins, so an update landing on
        // the wrap edge re-arms pend after the wrap consumed the previous shadow.
        if (hit) begin
          cyc_s <= CYCLE;
          div_s <= FREQ_DIV;
          pend  <= 1'b1;
        end
      end
    end

    assign SYNC_IDX[s] = idx;
    assign WRAP[s]     = wrap;
    assign PENDING[s]  = pend;
  end

endmodule

// File: tb/tb_modulation_sync_idx_gen.sv
// Self-checking bench: directed scenarios plus random traffic against an
// arithmetic model (index = elapsed clocks / divider, modulo cycle length).
module tb_modulation_sync_idx_gen;
  localparam int NS = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SYNC = 1'b0;
  logic        UPDATE_SETTINGS = 1'b0;
  logic [0:0]  UPDATE_SEGMENT = '0;
  logic [15:0] CYCLE = '0;
  logic [15:0] FREQ_DIV = '0;
  logic [15:0] SYNC_IDX [NS];
  logic        WRAP     [NS];
  logic        PENDING  [NS];

  int n_checks = 0;
  int n_errors = 0;

  // Model: clocks elapsed since the last alignment point plus active/shadow settings.
  longint m_k    [NS];
  int     m_cyc  [NS];
  int     m_div  [NS];
  int     m_cs   [NS];
  int     m_ds   [NS];
  bit     m_pend [NS];
  bit     m_wrap [NS];

  modulation_sync_idx_gen #(.NumSegment(NS)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .SYNC            (SYNC),
    .UPDATE_SETTINGS (UPDATE_SETTINGS),
    .UPDATE_SEGMENT  (UPDATE_SEGMENT),
    .CYCLE           (CYCLE),
    .FREQ_DIV        (FREQ_DIV),
    .SYNC_IDX        (SYNC_IDX),
    .WRAP            (WRAP),
    .PENDING         (PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint eff(input int d);
    return (d == 0) ? 64'd1 : longint'(d);
  endfunction

  function automatic longint period(input int s);
    return eff(m_div[s]) * longint'(m_cyc[s] + 1);
  endfunction

  function automatic longint m_idx(input int s);
    return (m_k[s] / eff(m_div[s])) % longint'(m_cyc[s] + 1);
  endfunction

  function automatic bit wrap_next(input int s);
    return ((m_k[s] + 1) % period(s)) == 0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_k[s] = 0; m_cyc[s] = 0; m_div[s] = 0; m_cs[s] = 0; m_ds[s] = 0;
      m_pend[s] = 1'b0; m_wrap[s] = 1'b0;
    end
  endtask

  task automatic model_step(input bit sy, input bit up, input int sg, input int c, input int d);
    for (int s = 0; s < NS; s++) begin
      bit hit;
      hit = up && (sg == s);
      if (sy) begin
        m_k[s] = 0;
        m_wrap[s] = 1'b0;
        if (hit) begin
          m_cyc[s] = c; m_div[s] = d; m_cs[s] = c; m_ds[s] = d;
        end else if (m_pend[s]) begin
          m_cyc[s] = m_cs[s]; m_div[s] = m_ds[s];
        end
        m_pend[s] = 1'b0;
      end else begin
        m_k[s]++;
        m_wrap[s] = (m_k[s] % period(s)) == 0;
        if (m_wrap[s] && m_pend[s]) begin
          m_cyc[s] = m_cs[s]; m_div[s] = m_ds[s];
          m_pend[s] = 1'b0;
          m_k[s] = 0;
        end
        if (hit) begin
          m_cs[s] = c; m_ds[s] = d; m_pend[s] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all(input string pfx);
    for (int s = 0; s < NS; s++) begin
      check($sformatf("%s_idx%0d", pfx, s), 32'(SYNC_IDX[s]), 32'(m_idx(s)));
      check($sformatf("%s_wrap%0d", pfx, s), 32'(WRAP[s]), 32'(m_wrap[s]));
      check($sformatf("%s_pend%0d", pfx, s), 32'(PENDING[s]), 32'(m_pend[s]));
    end
  endtask

  task automatic tick(input string pfx, input bit sy, input bit up, input int sg,
                      input int c, input int d);
    SYNC            = sy;
    UPDATE_SETTINGS = up;
    UPDATE_SEGMENT  = sg[0];
    CYCLE           = 16'(c);
    FREQ_DIV        = 16'(d);
    @(posedge CLK);
    model_step(sy, up, sg, c, d);
    #1;
    SYNC            = 1'b0;
    UPDATE_SETTINGS = 1'b0;
    check_all(pfx);
  endtask

  task automatic idle(input string pfx, input int n);
    repeat (n) tick(pfx, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_idx(input string pfx, input int s, input int v, input int budget);
    int i = 0;
    while (m_idx(s) != longint'(v) && i < budget) begin
      tick(pfx, 1'b0, 1'b0, 0, 0, 0);
      i++;
    end
    check({pfx, "_reach"}, 32'(SYNC_IDX[s]), 32'(v));
  endtask

  task automatic wait_wrap_next(input string pfx, input int s, input int budget);
    int i = 0;
    while (!wrap_next(s) && i < budget) begin
      tick(pfx, 1'b0, 1'b0, 0, 0, 0);
      i++;
    end
    check({pfx, "_budget"}, 32'(i < budget), 32'd1);
  endtask

  initial begin
    model_reset();
    #2;
    check_all("reset");
    #10 RST_N = 1'b1;

    // Default settings: CYCLE=0, divider 1 -> WRAP every clock, index stuck at 0.
    idle("default", 6);

    // Basic counting on seg0.
    tick("basic_upd", 1'b0, 1'b1, 0, 3, 2);
    tick("basic_sync", 1'b1, 1'b0, 0, 0, 0);
    idle("basic", 20);

    // Deferred update issued at idx=1.
    wait_idx("defer", 0, 1, 20);
    tick("defer_upd", 1'b0, 1'b1, 0, 1, 1);
    idle("defer", 14);

    // Two updates before the wrap; the last one wins.
    tick("ovw_upd5", 1'b0, 1'b1, 0, 5, 1);
    tick("ovw_upd2", 1'b0, 1'b1, 0, 2, 1);
    idle("ovw", 10);
    // Update coincident with the wrap edge.
    wait_wrap_next("coinc", 0, 50);
    tick("coinc_upd", 1'b0, 1'b1, 0, 4, 2);
    check("coinc_pend", 32'(PENDING[0]), 32'd1);
    check("coinc_wrap", 32'(WRAP[0]), 32'd1);
    idle("coinc", 8);

    // SYNC mid-cycle with a pending shadow.
    wait_idx("syncmid", 0, 2, 60);
    tick("syncmid_upd", 1'b0, 1'b1, 0, 6, 1);
    tick("syncmid_sync", 1'b1, 1'b0, 0, 0, 0);
    check("syncmid_idx0", 32'(SYNC_IDX[0]), 32'd0);
    check("syncmid_nowrap", 32'(WRAP[0]), 32'd0);
    check("syncmid_pend0", 32'(PENDING[0]), 32'd0);
    idle("syncmid", 10);

    // FREQ_DIV=0 steps every clock; then asynchronous reset mid-count.
    tick("div0_upd", 1'b1, 1'b1, 1, 7, 0);
    idle("div0", 5);
    check("div0_idx1", 32'(SYNC_IDX[1]), 32'd5);
    RST_N = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    #1 RST_N = 1'b1;
    idle("post_rst", 3);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      bit sy, up;
      sy = ($urandom_range(0, 39) == 0);
      up = ($urandom_range(0, 7) == 0);
      tick("rand", sy, up, int'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
           int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
